sram_bus_bridge: RTL and testbench
==================================

# sram_bus_bridge

Bridges the 32-bit CPU data bus to the 16-bit SRAM interface stage. Each 32-bit word access becomes two sequential half-word SRAM transactions, low half then high half. The bridge sits directly upstream of the SRAM interface: it drives that stage's enable/rw/address/wdata and consumes its rdata/ready.

## Interface
Parameters: none.

Ports:
- i_clock  in  1  system clock; all state changes on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_request  in  1  CPU access request, level; held until o_ready seen
- i_rw  in  1  0 = read, 1 = write
- i_address  in  32  CPU byte address; bits [18:2] used, others ignored
- i_wdata  in  32  write data
- o_rdata  out  32  read data, valid while o_ready = 1
- o_ready  out  1  access complete
- o_sram_enable  out  1  downstream enable
- o_sram_rw  out  1  downstream direction
- o_sram_address  out  18  downstream half-word address
- o_sram_wdata  out  16  downstream write data
- i_sram_rdata  in  16  downstream read data
- i_sram_ready  in  1  downstream completion, valid only while o_sram_enable = 1

## Operation
- States: IDLE, LO, GAP, HI, DONE.
- IDLE: when i_request = 1, latch i_rw, i_address[18:2] (tag) and i_wdata. Go to LO.
- LO: o_sram_enable = 1, o_sram_address = {tag, 1'b0}, o_sram_wdata = wdata[15:0].
  - On the edge where i_sram_ready = 1, capture i_sram_rdata into rdata[15:0] (reads only) and go to GAP.
- GAP: o_sram_enable = 0 for exactly one cycle, so the downstream stage returns to its start state. Go to HI.
- HI: o_sram_enable = 1, o_sram_address = {tag, 1'b1}, o_sram_wdata = wdata[31:16].
  - On i_sram_ready = 1, capture rdata[31:16] and go to DONE.
- DONE: o_ready = 1, o_sram_enable = 0. Stay while i_request = 1; go to IDLE on the first cycle i_request = 0.
  - A held request therefore never starts a second transaction.
- o_sram_rw = latched rw throughout LO/GAP/HI; 0 otherwise.
- o_rdata holds the last read word until overwritten. Writes do not modify it.
- Address mapping: half-word address = byte address[18:1] with bit 0 forced per half.
  - Byte addresses wrap modulo 512 KiB: 0x80000 aliases to 0x00000.
  - Bits [1:0] are ignored, so unaligned addresses are forced aligned.
- Request dropped mid-transaction is a protocol violation. The bridge completes both halves, passes through DONE for one cycle with o_ready = 1, then returns to IDLE.
- Reset (asynchronous, any state):
  - state = IDLE.
  - o_sram_enable, o_sram_rw, o_ready = 0.
  - o_sram_address, o_sram_wdata, o_rdata = 0.
  - Read cache invalidated.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from i_request to any output.
- Request sampled in IDLE: LO begins the next cycle.
- Total latency from request edge to o_ready = 1 + T_lo + 1 + T_hi + 1 cycles, where T_x is the number of cycles o_sram_enable is high in that phase.
- o_sram_address and o_sram_wdata are stable for the entire enable-high interval of each phase.
- i_sram_ready is ignored outside LO/HI.

## Configuration
- Macro SRAM_BRIDGE_READ_CACHE_EN.
- Defined: adds a single-entry read cache (valid bit, 17-bit tag, 32-bit data).
  - Read in IDLE with valid = 1 and tag match: go directly to DONE with o_rdata = cached data; o_ready is high the next cycle; no SRAM access.
  - Read miss: fill the cache on entering DONE.
  - Write with tag match: update the cached data with wdata on entering DONE.
  - Write with no match: cache unchanged.
- Undefined: no cache logic; every read performs both SRAM halves.

## Test plan
- Write 0xDEADBEEF to 0x00000100 -> downstream sees rw = 1, address 0x00080 with data 0xBEEF, then 0x00081 with 0xDEAD. o_ready rises once.
- Read 0x00000100 with a model returning 0xBEEF/0xDEAD -> o_rdata = 0xDEADBEEF. o_sram_enable is low exactly one cycle between halves.
- Hold i_request high for 10 cycles after o_ready -> o_ready stays 1 and no further o_sram_enable pulse occurs. Dropping the request returns the bridge to IDLE.
- Read 0x0007FFFC, then 0x00080000 -> half addresses 0x3FFFE/0x3FFFF, then 0x00000/0x00001.
- Assert i_reset during HI -> all outputs are 0 immediately. The next request starts at LO with correct addresses.
- With SRAM_BRIDGE_READ_CACHE_EN, read 0x100 twice -> the second read has o_ready one cycle after the request and no o_sram_enable.
  - Then write 0x12345678 to 0x100 and read 0x100 -> 0x12345678 returned from the cache.

Source files
------------

// File: rtl/sram_bus_bridge.sv
// sram_bus_bridge: 32-bit CPU data bus to 16-bit SRAM stage bridge.
// Each word access is split into a low half-word transaction and a high
// half-word transaction, separated by one idle cycle.
// Optional macro SRAM_BRIDGE_READ_CACHE_EN adds a single-entry read cache.
module sram_bus_bridge (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_sram_enable,
  output logic        o_sram_rw,
  output logic [17:0] o_sram_address,
  output logic [15:0] o_sram_wdata,
  input  logic [15:0] i_sram_rdata,
  input  logic        i_sram_ready
);

  typedef enum logic [2:0] {IDLE, LO, GAP, HI, DONE} state_t;

  state_t      state_q, state_d;
  logic        rw_q;
  logic [16:0] tag_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        cache_hit;
  logic        active;

  // Address bits outside [18:2] do not take part in the access.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^{i_address[31:19], i_address[1:0]};

`ifdef SRAM_BRIDGE_READ_CACHE_EN
  logic        cache_valid_q;
  logic [16:0] cache_tag_q;
  logic [31:0] cache_data_q;

  assign cache_hit = cache_valid_q && !i_rw && (cache_tag_q == i_address[18:2]);

  // Fill on read completion; keep coherent on writes to the cached word.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_data_q  <= '0;
    end else if (state_q == HI && i_sram_ready) begin
      if (!rw_q) begin
        cache_valid_q <= 1'b1;
        cache_tag_q   <= tag_q;
        cache_data_q  <= {i_sram_rdata, rdata_q[15:0]};
      end else if (cache_valid_q && cache_tag_q == tag_q) begin
        cache_data_q  <= wdata_q;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; DONE holds while the request stays high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_request)    state_d = cache_hit ? DONE : LO;
      LO:   if (i_sram_ready) state_d = GAP;
      GAP:                    state_d = HI;
      HI:   if (i_sram_ready) state_d = DONE;
      DONE: if (!i_request)   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Request latch and read data assembly.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rw_q    <= 1'b0;
      tag_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_request) begin
          rw_q    <= i_rw;
          tag_q   <= i_address[18:2];
          wdata_q <= i_wdata;
`ifdef SRAM_BRIDGE_READ_CACHE_EN
          if (cache_hit) rdata_q <= cache_data_q;
`endif
        end
        LO: if (i_sram_ready && !rw_q) rdata_q[15:0]  <= i_sram_rdata;
        HI: if (i_sram_ready && !rw_q) rdata_q[31:16] <= i_sram_rdata;
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    active         = (state_q == LO) || (state_q == GAP) || (state_q == HI);
    o_sram_enable  = (state_q == LO) || (state_q == HI);
    o_ready        = (state_q == DONE);
    o_sram_rw      = active && rw_q;
    o_sram_address = '0;
    o_sram_wdata   = '0;
    if (active) begin
      o_sram_address = {tag_q, (state_q == HI)};
      o_sram_wdata   = (state_q == HI) ? wdata_q[31:16] : wdata_q[15:0];
    end
    o_rdata        = rdata_q;
  end

endmodule

// File: tb/tb_sram_bus_bridge.sv
// Randomized bench for sram_bus_bridge against a word-level memory model.
module tb_sram_bus_bridge;

`ifdef SRAM_BRIDGE_READ_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic        i_clock, i_reset, i_request, i_rw;
  logic [31:0] i_address, i_wdata, o_rdata;
  logic        o_ready, o_sram_enable, o_sram_rw, i_sram_ready;
  logic [17:0] o_sram_address;
  logic [15:0] o_sram_wdata, i_sram_rdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] sram_mem [logic [17:0]];
  logic [31:0] ref_mem  [logic [16:0]];
  logic [31:0] last_rd;
  bit          c_valid;
  logic [16:0] c_tag;

  sram_bus_bridge dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_request(i_request), .i_rw(i_rw),
    .i_address(i_address), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_ready(o_ready),
    .o_sram_enable(o_sram_enable), .o_sram_rw(o_sram_rw), .o_sram_address(o_sram_address),
    .o_sram_wdata(o_sram_wdata), .i_sram_rdata(i_sram_rdata), .i_sram_ready(i_sram_ready)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] def_half(input logic [17:0] a);
    return a[15:0] ^ {a[17:16], 14'h2A5C};
  endfunction

  function automatic logic [15:0] sram_rd(input logic [17:0] a);
    if (sram_mem.exists(a)) return sram_mem[a];
    return def_half(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [16:0] t);
    if (ref_mem.exists(t)) return ref_mem[t];
    return {def_half({t, 1'b1}), def_half({t, 1'b0})};
  endfunction

  // Called just after a negedge; returns just after a negedge with the DUT idle.
  task automatic do_access(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                           input int hold, input bit drop_early);
    logic [16:0] t;
    bit hit, prev_en, seen_ready;
    int dly [2];
    int cyc, pulses, en_cnt, gap, ph, exp_cyc;
    t = addr[18:2];
    hit = CACHE_ON && c_valid && (c_tag == t) && !rw;
    dly[0] = $urandom_range(0, 3);
    dly[1] = $urandom_range(0, 3);
    i_request = 1'b1; i_rw = rw; i_address = addr; i_wdata = wd;
    cyc = 1; pulses = 0; en_cnt = 0; gap = 0; prev_en = 1'b0; seen_ready = 1'b0;
    while (!seen_ready && cyc < 60) begin
      @(negedge i_clock);
      cyc++;
      if (o_sram_enable) begin
        if (!prev_en) begin
          pulses++;
          en_cnt = 0;
          if (pulses == 2) check("gap_len", gap, 1);
        end
        en_cnt++;
        ph = (pulses >= 2) ? 1 : 0;
        check("sram_addr", {14'd0, o_sram_address}, {14'd0, t, ph[0]});
        check("sram_rw", {31'd0, o_sram_rw}, {31'd0, rw});
        if (rw) check("sram_wdata", {16'd0, o_sram_wdata}, {16'd0, ph[0] ? wd[31:16] : wd[15:0]});
        if (en_cnt == dly[ph] + 1) begin
          i_sram_ready = 1'b1;
          if (o_sram_rw) begin
            sram_mem[o_sram_address] = o_sram_wdata;
            i_sram_rdata = 16'($urandom);
          end else begin
            i_sram_rdata = sram_rd(o_sram_address);
          end
        end else begin
          i_sram_ready = 1'b0;
          i_sram_rdata = 16'($urandom);
        end
      end else begin
        if (pulses == 1) gap++;
        i_sram_ready = 1'($urandom_range(0, 1));
        i_sram_rdata = 16'($urandom);
      end
      prev_en = o_sram_enable;
      if (o_ready) seen_ready = 1'b1;
      i_address = $urandom;
      i_wdata   = $urandom;
      if (drop_early) i_request = 1'b0;
    end
    check("ready_seen", {31'd0, seen_ready}, 32'd1);
    exp_cyc = hit ? 2 : (1 + (dly[0] + 1) + 1 + (dly[1] + 1) + 1);
    check("latency", cyc, exp_cyc);
    check("pulses", pulses, hit ? 0 : 2);
    if (rw) begin
      ref_mem[t] = wd;
    end else begin
      last_rd = ref_rd(t);
      if (!hit) begin c_valid = 1'b1; c_tag = t; end
    end
    check("rdata", o_rdata, last_rd);
    if (!drop_early) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge i_clock);
        check("hold_ready", {31'd0, o_ready}, 32'd1);
        check("hold_enable", {31'd0, o_sram_enable}, 32'd0);
        i_sram_ready = 1'($urandom_range(0, 1));
      end
    end
    i_request = 1'b0;
    @(negedge i_clock);
    check("back_idle", {31'd0, o_ready}, 32'd0);
    i_sram_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en"},    {31'd0, o_sram_enable}, 32'd0);
    check({tag, "_rw"},    {31'd0, o_sram_rw}, 32'd0);
    check({tag, "_ready"}, {31'd0, o_ready}, 32'd0);
    check({tag, "_addr"},  {14'd0, o_sram_address}, 32'd0);
    check({tag, "_wdata"}, {16'd0, o_sram_wdata}, 32'd0);
    check({tag, "_rdata"}, o_rdata, 32'd0);
  endtask

  task automatic reset_in_hi(input logic [31:0] addr, input logic [31:0] wd);
    int cyc;
    bit in_hi;
    cyc = 0; in_hi = 1'b0;
    i_request = 1'b1; i_rw = 1'b1; i_address = addr; i_wdata = wd;
    while (!in_hi && cyc < 40) begin
      @(negedge i_clock);
      cyc++;
      if (o_sram_enable && o_sram_address[0]) begin
        in_hi = 1'b1;
      end else begin
        i_sram_ready = o_sram_enable;
        if (o_sram_enable) sram_mem[o_sram_address] = o_sram_wdata;
      end
    end
    check("reach_hi", {31'd0, in_hi}, 32'd1);
    #2;
    i_reset = 1'b1; i_request = 1'b0; i_sram_ready = 1'b0;
    #1;
    check_all_zero("rst_hi");
    @(negedge i_clock);
    i_reset = 1'b0;
    last_rd = '0;
    c_valid = 1'b0;
  endtask

  initial begin
    logic [16:0] pool [8];
    logic [31:0] a;
    i_reset = 1'b1; i_request = 1'b0; i_rw = 1'b0; i_address = '0; i_wdata = '0;
    i_sram_ready = 1'b0; i_sram_rdata = '0;
    last_rd = '0; c_valid = 1'b0; c_tag = '0;
    @(negedge i_clock);
    @(negedge i_clock);
    check_all_zero("reset");
    i_reset = 1'b0;
    @(negedge i_clock);

    do_access(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 0, 1'b0);
    check("wr_lo_half", {16'd0, sram_rd(18'h00080)}, 32'h0000_BEEF);
    check("wr_hi_half", {16'd0, sram_rd(18'h00081)}, 32'h0000_DEAD);
    do_access(1'b0, 32'h0000_0100, 32'h0, 10, 1'b0);
    check("rd_deadbeef", o_rdata, 32'hDEAD_BEEF);
    do_access(1'b0, 32'h0000_0100, 32'h0, 0, 1'b0);
    do_access(1'b1, 32'h0000_0100, 32'h1234_5678, 0, 1'b0);
    do_access(1'b0, 32'h0000_0100, 32'h0, 0, 1'b0);
    check("rd_12345678", o_rdata, 32'h1234_5678);
    do_access(1'b0, 32'h0007_FFFC, 32'h0, 0, 1'b0);
    do_access(1'b0, 32'h0008_0000, 32'h0, 0, 1'b0);
    do_access(1'b0, 32'h0000_0103, 32'h0, 1, 1'b0);
    do_access(1'b0, 32'h0000_2000, 32'h0, 0, 1'b1);
    do_access(1'b1, 32'h0000_2000, 32'hA5A5_0F0F, 0, 1'b1);

    reset_in_hi(32'h0001_2344, 32'hCAFE_F00D);
    do_access(1'b1, 32'h0001_2344, 32'h0BAD_F00D, 0, 1'b0);
    do_access(1'b0, 32'h0001_2344, 32'h0, 0, 1'b0);
    check("rd_after_rst", o_rdata, 32'h0BAD_F00D);

    pool[0] = 17'h00000;
    pool[1] = 17'h1FFFF;
    for (int i = 2; i < 8; i++) pool[i] = 17'($urandom);
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      a[18:2] = pool[$urandom_range(0, 7)];
      do_access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3),
                ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
